// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead slice per
// stage, carry rippled through stage registers, elastic valid/ready on both sides.
module cla_pipelined_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSTAGE = WIDTH / GROUP;
    localparam int unsigned LAST   = NSTAGE - 1;

    // Returns {carry out, carry into MSB, sum} using flattened generate/propagate terms.
    function automatic logic [GROUP+1:0] cla_slice(
        input logic [GROUP-1:0] a,
        input logic [GROUP-1:0] b,
        input logic             ci
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             pp;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < int'(GROUP); i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & ci);
        end
        return {c[GROUP], c[GROUP-1], p ^ c[GROUP-1:0]};
    endfunction

    logic [NSTAGE-1:0] r_valid;
    logic [WIDTH-1:0]  r_xs  [NSTAGE];
    logic [WIDTH-1:0]  r_ys  [NSTAGE];
    logic [WIDTH-1:0]  r_sum [NSTAGE];
    logic              r_c   [NSTAGE];
    logic              r_ovf;

    logic [WIDTH-1:0]  w_a   [NSTAGE];
    logic [WIDTH-1:0]  w_b   [NSTAGE];
    logic [WIDTH-1:0]  w_si  [NSTAGE];
    logic              w_ci  [NSTAGE];
    logic [GROUP+1:0]  w_res [NSTAGE];
    logic [NSTAGE-1:0] w_vin;
    logic [NSTAGE-1:0] w_can;

    for (genvar k = 0; k < int'(NSTAGE); k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_a[k]   = x;
            assign w_b[k]   = y ^ {WIDTH{sub}};
            assign w_ci[k]  = cin;
            assign w_si[k]  = '0;
            assign w_vin[k] = in_valid;
        end else begin : g_body
            assign w_a[k]   = r_xs[k-1];
            assign w_b[k]   = r_ys[k-1];
            assign w_ci[k]  = r_c[k-1];
            assign w_si[k]  = r_sum[k-1];
            assign w_vin[k] = r_valid[k-1];
        end

        assign w_res[k] = cla_slice(w_a[k][GROUP-1:0], w_b[k][GROUP-1:0], w_ci[k]);
        // A stage can load if any stage at or beyond it is empty, or the output drains.
        assign w_can[k] = out_ready | ~(&r_valid[LAST:k]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid[k] <= 1'b0;
                r_sum[k]   <= '0;
                r_c[k]     <= 1'b0;
            end else if (w_can[k]) begin
                r_valid[k] <= w_vin[k];
                if (w_vin[k]) begin
                    r_sum[k] <= w_si[k] | (WIDTH'(w_res[k][GROUP-1:0]) << (k * GROUP));
                    r_c[k]   <= w_res[k][GROUP+1];
                end
            end
        end

        // Remaining upper operand slices shift down one group per stage.
        if (k < int'(LAST)) begin : g_skew
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_xs[k] <= '0;
                    r_ys[k] <= '0;
                end else if (w_can[k] && w_vin[k]) begin
                    r_xs[k] <= w_a[k] >> GROUP;
                    r_ys[k] <= w_b[k] >> GROUP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_can[LAST] && w_vin[LAST]) begin
            r_ovf <= ^w_res[LAST][GROUP+1:GROUP];
        end
    end

    assign in_ready  = w_can[0];
    assign out_valid = r_valid[LAST];
    assign s         = r_sum[LAST];
    assign cout      = r_c[LAST];
    assign ovf       = r_ovf;

endmodule
